scope_trace_render: RTL and testbench

//  Pixel-colour stage fed by the 640x480 VGA timing generator (x, y, video_on, p_tick).

---
 rtl/scope_trace_render.sv | 224 ++++++++++++++++++++++
 tb/tb_scope_trace_render.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_trace_render.sv
// -----------------------------------------------------------------------------
// scope_trace_render
//   Pixel-colour stage of a simple digital oscilloscope. It sits behind a
//   640x480 VGA timing generator and does two jobs:
//     * capture: decimates the incoming ADC samples and waits for a rising
//       trigger edge. It then fills the back half of a ping-pong pair of line
//       buffers, one sample per visible column. The halves swap only at frame
//       end, so the displayed trace never tears.
//     * render: draws the trace, the trigger-level marker and a graticule as
//       12-bit RGB. Adjacent columns are joined vertically so steep edges
//       appear as solid lines.
//
// Ports
//   clk          system clock (p_tick is high on every second clk)
//   reset        asynchronous, active-high
//   sample_valid one ADC sample offered this clk
//   sample       unsigned ADC code
//   trig_level   rising-edge trigger threshold
//   decim        keep 1 of every decim+1 valid samples
//   p_tick       pixel enable from the timing generator
//   video_on     x,y inside the visible area
//   x, y         current pixel coordinates
//   rgb          {R4,G4,B4} pixel colour, registered
//   armed        capture FSM waiting for a trigger
//   swapped      1-clk pulse when the front buffer changes
// -----------------------------------------------------------------------------
module scope_trace_render #(
  parameter int SAMPLE_W   = 8,
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int V_OFFSET   = 112,
  parameter int GRID_SHIFT = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [15:0]         decim,
  input  logic                p_tick,
  input  logic                video_on,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  output logic [11:0]         rgb,
  output logic                armed,
  output logic                swapped
);

  localparam int AW = $clog2(H_DISPLAY);
  // Screen row of sample code 0. Larger codes plot higher on the screen.
  localparam logic [9:0] ROW_BASE = 10'(V_OFFSET + (2 ** SAMPLE_W) - 1);

  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_TRACE = 12'h0F0;
  localparam logic [11:0] C_TRIG  = 12'h840;
  localparam logic [11:0] C_GRID  = 12'h444;

  typedef enum logic [1:0] {ST_ARM, ST_FILL, ST_DONE} state_t;

  // ---------------------------------------------------------------------------
  // Capture side
  // ---------------------------------------------------------------------------
  state_t              state;
  logic                front_sel;
  logic                front_valid;
  logic                prev_ok;
  logic [SAMPLE_W-1:0] prev_s;
  logic [15:0]         decim_cnt;
  logic [AW-1:0]       wr_addr;

  logic [SAMPLE_W-1:0] buf0 [H_DISPLAY];
  logic [SAMPLE_W-1:0] buf1 [H_DISPLAY];

  logic          accept;
  logic          trig_hit;
  logic          frame_end;
  logic          wr_en;
  logic [AW-1:0] wr_idx;

  assign accept    = sample_valid && (decim_cnt >= decim);
  assign trig_hit  = prev_ok && (prev_s < trig_level) && (sample >= trig_level);
  assign frame_end = p_tick && (x == 10'(H_DISPLAY - 1)) && (y == 10'(V_DISPLAY - 1));
  // The triggering sample itself becomes column 0.
  assign wr_en     = accept && (((state == ST_ARM) && trig_hit) || (state == ST_FILL));
  assign wr_idx    = (state == ST_ARM) ? '0 : wr_addr;

  // NOTE: the buffers have no reset. Their contents are meaningless until a
  // complete capture has been swapped in, and front_valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel) buf0[wr_idx] <= sample;
      else           buf1[wr_idx] <= sample;
    end
  end

  // NOTE: every register below uses non-blocking assignments. Later
  // assignments to the same register in one clk then override earlier ones
  // (e.g. prev_ok cleared at swap), and no read sees a half-updated value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ARM;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      prev_ok     <= 1'b0;
      prev_s      <= '0;
      decim_cnt   <= '0;
      wr_addr     <= '0;
      armed       <= 1'b1;
      swapped     <= 1'b0;
    end else begin
      swapped <= 1'b0;

      // The decimator keeps counting in every state, so the sample phase
      // stays continuous across captures.
      if (sample_valid) decim_cnt <= accept ? 16'd0 : decim_cnt + 16'd1;

      if (accept) begin
        prev_s  <= sample;
        prev_ok <= 1'b1;
      end

      unique case (state)
        ST_ARM: begin
          if (accept && trig_hit) begin
            wr_addr <= AW'(1);
            state   <= ST_FILL;
            armed   <= 1'b0;
          end
        end
        ST_FILL: begin
          if (accept) begin
            wr_addr <= wr_addr + AW'(1);
            if (wr_addr == AW'(H_DISPLAY - 1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (frame_end) begin
            front_sel   <= ~front_sel;
            front_valid <= 1'b1;
            swapped     <= 1'b1;
            // The next trigger must see a fresh rising edge.
            prev_ok     <= 1'b0;
            state       <= ST_ARM;
            armed       <= 1'b1;
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Render side: stage 1 on the p_tick clk, rgb one clk later
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] rd_s;
  logic [9:0]          x1;
  logic [9:0]          y1;
  logic                von1;
  logic                fv1;
  logic                tick1;
  logic [9:0]          last_row;

  // Read port kept free of reset so it can map onto block-RAM output regs.
  always_ff @(posedge clk) begin
    if (p_tick && (x < 10'(H_DISPLAY))) begin
      rd_s <= front_sel ? buf1[x[AW-1:0]] : buf0[x[AW-1:0]];
    end
  end

  logic [9:0]  row;
  logic [9:0]  ref_row;
  logic [9:0]  lo_row;
  logic [9:0]  hi_row;
  logic [9:0]  trig_row;
  logic        on_trace;
  logic        on_grid;
  logic [11:0] pix_rgb;

  assign row      = ROW_BASE - 10'(rd_s);
  // Column 0 has no left neighbour, so it joins only to itself.
  assign ref_row  = (x1 == '0) ? row : last_row;
  assign lo_row   = (ref_row < row) ? ref_row : row;
  assign hi_row   = (ref_row < row) ? row : ref_row;
  assign trig_row = ROW_BASE - 10'(trig_level);
  assign on_trace = fv1 && (y1 >= lo_row) && (y1 <= hi_row);
  assign on_grid  = (x1[GRID_SHIFT-1:0] == '0) || (y1[GRID_SHIFT-1:0] == '0) ||
                    (x1 == 10'(H_DISPLAY - 1)) || (y1 == 10'(V_DISPLAY - 1));

  // NOTE: pix_rgb takes a default before the priority chain, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    pix_rgb = C_BLACK;
    if (!von1)                pix_rgb = C_BLACK;
    else if (on_trace)        pix_rgb = C_TRACE;
    else if (y1 == trig_row)  pix_rgb = C_TRIG;
    else if (on_grid)         pix_rgb = C_GRID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1       <= '0;
      y1       <= '0;
      von1     <= 1'b0;
      fv1      <= 1'b0;
      tick1    <= 1'b0;
      last_row <= '0;
      rgb      <= C_BLACK;
    end else begin
      tick1 <= p_tick;
      if (p_tick) begin
        x1   <= x;
        y1   <= y;
        von1 <= video_on;
        // Latched with the read, so data and validity come from the same buffer.
        fv1  <= front_valid;
      end
      if (tick1) begin
        rgb      <= pix_rgb;
        last_row <= row;
      end
    end
  end

endmodule

// File: tb/tb_scope_trace_render.sv
// -----------------------------------------------------------------------------
// tb_scope_trace_render
//   Randomised scoreboard bench for scope_trace_render. The stimulus process
//   acts as the timing generator and ADC. Each issued pixel pushes its expected
//   colour, taken from a buffer-level reference model. A monitor pops and
//   compares when the pixel's rgb appears. armed/swapped are compared every clk.
// -----------------------------------------------------------------------------
module tb_scope_trace_render;

  localparam int H    = 640;
  localparam int V    = 480;
  localparam int VOFF = 112;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [7:0]  sample;
  logic [7:0]  trig_level;
  logic [15:0] decim;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] rgb;
  logic        armed;
  logic        swapped;

  always #5 clk = ~clk;

  scope_trace_render dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .decim        (decim),
    .p_tick       (p_tick),
    .video_on     (video_on),
    .x            (x),
    .y            (y),
    .rgb          (rgb),
    .armed        (armed),
    .swapped      (swapped)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: displayed samples, the capture in progress as a queue
  // ---------------------------------------------------------------------------
  int  front_m [H];
  bit  fv_m;
  int  back_q [$];
  bit  prev_ok_m;
  int  prev_m;
  int  dcnt_m;
  int  last_row_m;
  bit  m_armed;
  bit  m_swapped;

  typedef struct {
    logic [11:0] val;
    int          px;
    int          py;
  } exp_t;
  exp_t exp_q [$];

  function automatic int row_of(input int code);
    return VOFF + 255 - code;
  endfunction

  function automatic logic [11:0] render_model(input int px, input int py, input bit von);
    int r;
    int lr;
    int lo;
    int hi;
    r  = row_of(front_m[px]);
    lr = (px == 0) ? r : last_row_m;
    last_row_m = r;
    lo = (lr < r) ? lr : r;
    hi = (lr < r) ? r : lr;
    if (!von) return 12'h000;
    if (fv_m && py >= lo && py <= hi) return 12'h0F0;
    if (py == row_of(int'(trig_level))) return 12'h840;
    if (px % 64 == 0 || py % 64 == 0 || px == H - 1 || py == V - 1) return 12'h444;
    return 12'h000;
  endfunction

  // Effect of one clk edge on the capture model.
  task automatic model_edge(input bit sv, input int s, input bit fe);
    bit acc;
    acc = 1'b0;
    m_swapped = 1'b0;
    if (sv) begin
      if (dcnt_m >= int'(decim)) begin
        acc = 1'b1;
        dcnt_m = 0;
      end else begin
        dcnt_m++;
      end
    end
    if (back_q.size() == H) begin
      if (fe) begin
        foreach (front_m[i]) front_m[i] = back_q[i];
        fv_m = 1'b1;
        m_swapped = 1'b1;
        back_q.delete();
      end
    end else if (acc) begin
      if (back_q.size() > 0 ||
          (prev_ok_m && prev_m < int'(trig_level) && s >= int'(trig_level)))
        back_q.push_back(s);
    end
    if (acc) begin
      prev_m = s;
      prev_ok_m = 1'b1;
    end
    if (m_swapped) prev_ok_m = 1'b0;
    m_armed = (back_q.size() == 0);
  endtask

  task automatic model_reset();
    fv_m = 1'b0;
    back_q.delete();
    prev_ok_m = 1'b0;
    prev_m = 0;
    dcnt_m = 0;
    last_row_m = 0;
    m_armed = 1'b1;
    m_swapped = 1'b0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit sv, input int s, input bit pt,
                       input int px, input int py, input bit von);
    @(negedge clk);
    check("armed", armed, m_armed);
    check("swapped", swapped, m_swapped);
    sample_valid = sv;
    sample       = 8'(s);
    p_tick       = pt;
    x            = 10'(px);
    y            = 10'(py);
    video_on     = von;
    if (pt) exp_q.push_back('{render_model(px, py, von), px, py});
    model_edge(sv, s, pt && px == H - 1 && py == V - 1);
  endtask

  task automatic pixel(input int px, input int py, input bit von);
    cycle(1'b0, 0, 1'b1, px, py, von);
    cycle(1'b0, 0, 1'b0, px, py, von);
  endtask

  task automatic frame_end();
    pixel(H - 1, V - 1, 1'b1);
  endtask

  task automatic samp(input int s);
    cycle(1'b1, s, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic rand_pixels(input int n);
    repeat (n) pixel($urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 7) != 0);
  endtask

  task automatic rand_line();
    int ly;
    ly = $urandom_range(100, 380);
    for (int i = 0; i < H; i++) pixel(i, ly, 1'b1);
  endtask

  task automatic fill_random(input int target);
    for (int g = 0; g < 4000 && back_q.size() < target; g++) samp($urandom_range(0, 255));
    check("fill_reached", back_q.size(), target);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: rgb for a pixel is valid two clks after its p_tick edge
  // ---------------------------------------------------------------------------
  logic tq1;
  logic tq2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tq1 <= 1'b0;
      tq2 <= 1'b0;
    end else begin
      tq1 <= p_tick;
      tq2 <= tq1;
    end
  end

  always @(negedge clk) begin
    if (!reset && tq2) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rgb_unexpected: got %0h with no pixel pending", rgb);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rgb(%0d,%0d)", e.px, e.py), rgb, e.val);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    trig_level   = 8'd128;
    decim        = 16'd0;
    p_tick       = 1'b0;
    video_on     = 1'b0;
    x            = '0;
    y            = '0;
    foreach (front_m[i]) front_m[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle frame after reset: graticule, blank and trigger marker only.
    pixel(0, 0, 1'b1);
    pixel(1, 1, 1'b1);
    pixel(1, 239, 1'b1);
    rand_pixels(100);
    frame_end();
    rand_pixels(20);

    // 3: constant input below the level never triggers.
    repeat (3) begin
      repeat (100) samp(50);
      rand_pixels(40);
      frame_end();
    end

    // 2: ramp, trigger at 128, swap at the next frame end.
    for (int i = 0; i < 1200 && back_q.size() < H; i++) samp(i % 256);
    check("ramp_first", (back_q.size() > 0) ? back_q[0] : -1, 128);
    repeat (5) samp($urandom_range(0, 255));
    pixel(0, 239, 1'b1);
    frame_end();
    pixel(0, 239, 1'b1);
    rand_line();
    rand_pixels(100);

    // 4: last write coincides with frame end -> swap deferred one frame.
    samp(0);
    samp(200);
    fill_random(H - 1);
    cycle(1'b1, $urandom_range(0, 255), 1'b1, H - 1, V - 1, 1'b1);
    cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
    rand_pixels(30);
    frame_end();
    rand_pixels(100);

    // 5: decimation by 4 with random data.
    decim = 16'd3;
    repeat (8) samp(0);
    repeat (8) samp(200);
    fill_random(H);
    frame_end();
    rand_line();
    rand_pixels(100);

    // 6: full-scale step between columns 9 and 10.
    decim = 16'd0;
    samp(0);
    samp(200);
    for (int k = 1; k < H; k++) begin
      if (k == 8 || k == 9) samp(0);
      else if (k == 10)     samp(255);
      else                  samp($urandom_range(0, 255));
    end
    frame_end();
    for (int ry = 100; ry <= 380; ry++) begin
      pixel(8, ry, 1'b1);
      pixel(9, ry, 1'b1);
      pixel(10, ry, 1'b1);
    end

    // 7: reset in the middle of a fill.
    pixel(0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
    samp(0);
    samp(200);
    repeat (50) samp($urandom_range(0, 255));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_rgb", rgb, 12'h000);
    check("reset_armed", armed, 1'b1);
    check("reset_swapped", swapped, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pixel(0, 239, 1'b1);
    rand_line();
    frame_end();
    rand_pixels(50);

    repeat (4) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
    check("pending_pixels", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
